// File: rtl/cache_fill_fsm_pkg.sv
// Purpose : shared constants and state encoding for the cache block fill engine.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: fill_state_e encoding, block geometry constants, word-offset helper.
package cache_fill_fsm_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_e;

   localparam int BLOCK_WORDS = 8;   // 16-bit words per cache block
   localparam int BLK_OFF_W   = 4;   // byte-offset bits inside a 16-byte block
   localparam int WORD_STEP   = 2;   // byte distance between consecutive words

   // Byte offset of word number idx inside a block.
   function automatic int unsigned word_offset(input int unsigned idx);
      return idx * WORD_STEP;
   endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Purpose : bundles the miss, memory and cache-array signals of the fill engine.
// Latency : n/a (wires only).
// Backpressure: none; the pipeline is stalled through fsm_busy.
// Ports   : master = fill engine side, slave = cache/memory/pipeline side.
interface cache_fill_fsm_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              miss_detected;
   logic [ADDR_W-1:0] miss_address;
   logic              memory_data_valid;
   logic [DATA_W-1:0] memory_data;
   logic              fsm_busy;
   logic              mem_read_en;
   logic [ADDR_W-1:0] memory_address;
   logic              write_data_array;
   logic              write_tag_array;
   logic [ADDR_W-1:0] cache_addr;
   logic [DATA_W-1:0] cache_data;

   modport master (
      input  miss_detected, miss_address, memory_data_valid, memory_data,
      output fsm_busy, mem_read_en, memory_address,
             write_data_array, write_tag_array, cache_addr, cache_data
   );

   modport slave (
      output miss_detected, miss_address, memory_data_valid, memory_data,
      input  fsm_busy, mem_read_en, memory_address,
             write_data_array, write_tag_array, cache_addr, cache_data
   );
endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Purpose : small word counter with enable, synchronous clear and terminal flag.
// Latency : count updates one cycle after en; wrap is combinational from cnt.
// Backpressure: none; holds its value while en is low.
// Ports   : clk, rst_n (async active-low), en, clr -> cnt, wrap (cnt at all-ones).
module fill_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Flag is independent of en so the caller can qualify it without a
   // combinational loop back through its own enable logic.
   assign wrap = (cnt == '1);

endmodule

// File: rtl/cache_fill_fsm.sv
// Purpose : on a cache miss, reads one block from pipelined memory and writes it into the cache arrays.
// Latency : reads start the cycle after the miss; each returned word is written the same cycle it arrives.
// Backpressure: none from memory; fsm_busy stalls the pipeline from miss until the tag write.
// Ports   : clk, rst_n (async active-low), bus (cache_fill_fsm_if.master: miss in, memory in/out, cache array writes out).
module cache_fill_fsm
   import cache_fill_fsm_pkg::*;
#(
   parameter int WORDS_PER_BLOCK = BLOCK_WORDS,
   parameter int ADDR_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   cache_fill_fsm_if.master bus
);

   localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << BLK_OFF_W) - 1);

   fill_state_e       state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              issue_done_q, issue_done_d;

   logic [CNT_W-1:0]  issue_cnt, recv_cnt;
   logic              issue_en, recv_en, cnt_clr;
   logic              issue_wrap, recv_wrap;

   logic              busy_raw;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              wr_data;
   logic              wr_tag;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_dat;

   fill_counter #(.CNT_W(CNT_W)) u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (issue_en),
      .clr   (cnt_clr),
      .cnt   (issue_cnt),
      .wrap  (issue_wrap)
   );

   fill_counter #(.CNT_W(CNT_W)) u_recv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (recv_en),
      .clr   (cnt_clr),
      .cnt   (recv_cnt),
      .wrap  (recv_wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         base_q       <= '0;
         issue_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         issue_done_q <= issue_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      issue_done_d = issue_done_q;
      cnt_clr      = 1'b0;
      issue_en     = 1'b0;
      recv_en      = 1'b0;
      busy_raw     = 1'b0;
      rd_en        = 1'b0;
      rd_addr      = '0;
      wr_data      = 1'b0;
      wr_tag       = 1'b0;
      wr_addr      = '0;
      wr_dat       = '0;

      case (state_q)
         ST_IDLE: begin
            // Memory responses arriving here are leftovers of an aborted
            // fill and are dropped.
            if (bus.miss_detected) begin
               busy_raw     = 1'b1;
               state_d      = ST_FILL;
               base_d       = bus.miss_address & ~OFF_MASK;
               issue_done_d = 1'b0;
               cnt_clr      = 1'b1;
            end
         end

         ST_FILL: begin
            busy_raw = 1'b1;

            // Issue side: one read per cycle until the whole block is requested.
            // Base has zero low bits, so OR-ing the offset never carries out.
            if (!issue_done_q) begin
               rd_en    = 1'b1;
               rd_addr  = base_q | ADDR_W'(word_offset(32'(issue_cnt)));
               issue_en = 1'b1;
               if (issue_wrap) begin
                  issue_done_d = 1'b1;
               end
            end

            // Receive side: words land in return order, independent of issue.
            if (bus.memory_data_valid) begin
               wr_data = 1'b1;
               wr_addr = base_q | ADDR_W'(word_offset(32'(recv_cnt)));
               wr_dat  = bus.memory_data;
               recv_en = 1'b1;
               if (recv_wrap) begin
                  wr_tag  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State is already IDLE during reset; only the miss-driven stall needs masking.
   assign bus.fsm_busy         = busy_raw & rst_n;
   assign bus.mem_read_en      = rd_en;
   assign bus.memory_address   = rd_addr;
   assign bus.write_data_array = wr_data;
   assign bus.write_tag_array  = wr_tag;
   assign bus.cache_addr       = wr_addr;
   assign bus.cache_data       = wr_dat;

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter WORDS_PER_BLOCK, default 8: 16-bit words per cache block (16-byte block).
REQ-002 Parameter ADDR_W, default 16: byte address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 miss_detected  input  1  cache lookup missed this cycle (D or I cache Miss).
REQ-006 miss_address  input  16  CPU byte address that missed.
REQ-007 memory_data_valid  input  1  memory returns one word this cycle.
REQ-008 memory_data  input  16  returned word, qualified by memory_data_valid.
REQ-009 fsm_busy  output  1  stall request to pipeline/cache arbiter.
REQ-010 mem_read_en  output  1  issue one read to pipelined memory this cycle.
REQ-011 memory_address  output  16  read address, qualified by mem_read_en.
REQ-012 write_data_array  output  1  cache data-array write enable (drives cache Data_WE).
REQ-013 write_tag_array  output  1  cache metadata write enable (drives cache MetaData_WE).
REQ-014 cache_addr  output  16  cache fill address (drives cache Addr_FSM).
REQ-015 cache_data  output  16  cache fill data (drives cache DataIn_FSM).

Function
REQ-016 Two states: IDLE, FILL; encoding in shared constants.
REQ-017 IDLE -> FILL on rising edge with miss_detected=1; latch base = {miss_address[15:4], 4'b0}; clear issue_cnt and recv_cnt (3-bit each).
REQ-018 fsm_busy = 1 combinationally in IDLE when miss_detected=1, and for every cycle in FILL; 0 otherwise.
REQ-019 FILL, issue_done=0: mem_read_en=1, memory_address = base + 2*issue_cnt; issue_cnt increments each cycle; issue_done set after the 8th issue (issue_cnt wraps 7->0 with flag).
REQ-020 Exactly 8 reads per fill, on 8 consecutive cycles starting the first FILL cycle; mem_read_en=0 otherwise.
REQ-021 FILL with memory_data_valid=1: write_data_array=1, cache_addr = base + 2*recv_cnt, cache_data = memory_data (combinational pass-through, zero added latency); recv_cnt increments.
REQ-022 Memory latency not assumed; gaps between valids tolerated; words written strictly in return order.
REQ-023 On the 8th valid word: write_tag_array=1 same cycle, cache_addr = miss base + 0xE; FILL -> IDLE at next edge.
REQ-024 write_tag_array asserts exactly once per completed fill, never in IDLE.
REQ-025 miss_detected and miss_address ignored while in FILL; a miss sampled in IDLE the cycle after return starts a new fill.
REQ-026 memory_data_valid in IDLE ignored: no array writes.
REQ-027 Outputs qualified-off (enables 0) drive cache_addr, cache_data, memory_address = 0.

Reset
REQ-028 rst_n=0 forces immediately: state IDLE, counters 0, issue_done 0, base 0, all outputs 0 (fsm_busy 0 unless miss_detected while released? no: fsm_busy 0 while rst_n=0).
REQ-029 Reset mid-fill aborts fill; no tag write; stale memory responses after release ignored per REQ-026.

Structure
REQ-030 Shared constants file: state encoding, WORDS_PER_BLOCK, block offset width (4), word step (2).
REQ-031 One sub-module: fill_counter (3-bit, enable, sync clear, async active-low reset, wrap flag), instanced twice (issue, receive).
REQ-032 Target 120-250 lines RTL; no memories inside block.

Verification
REQ-033 Miss 0x1234 in IDLE, memory latency 4, data 0xA000+i -> reads 0x1230..0x123E on FILL cycles 0-7; data writes 0x1230..0x123E with 0xA000..0xA007 on cycles 4-11; tag write cycle 11; fsm_busy low cycle 12.
REQ-034 Gapped returns (valid every 2nd cycle) for miss 0x00F0 -> 8 writes 0x00F0..0x00FE in order; single tag write on 8th; busy held throughout.
REQ-035 miss_detected held high with miss_address changing to 0x8000 during fill of 0x4000 -> all writes in 0x4000..0x400E; second fill at 0x8000 begins cycle after return.
REQ-036 rst_n low after 3 data writes of miss 0x2000 -> outputs 0 immediately; no tag write; remaining memory valids after release cause no writes.
REQ-037 memory_data_valid pulses in IDLE with miss_detected=0 -> write_data_array, write_tag_array, fsm_busy remain 0.
REQ-038 Miss at 0xFFFE -> reads 0xFFF0..0xFFFE, no address overflow past 0xFFFE.
